// File: rtl/fl_test_utils_pkg.sv
// fl_test_utils_pkg: shared types and default widths for the test-utility monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: RUN/DONE state enum, status struct, default parameter constants.
package fl_test_utils_pkg;

  localparam int FL_DEFAULT_WIDTH     = 32;
  localparam int FL_DEFAULT_CNT_WIDTH = 16;
  localparam int FL_DEFAULT_TIMEOUT   = 10000;
  localparam int FL_CYCLE_WIDTH       = 32;

  // RUN after reset; DONE is sticky until reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Verdict-relevant status at the default counter width.
  typedef struct packed {
    logic [FL_DEFAULT_CNT_WIDTH-1:0] n_checks;
    logic [FL_DEFAULT_CNT_WIDTH-1:0] n_fails;
    logic                            fail;
    logic                            timeout;
    logic                            done;
  } status_t;

endpackage

// File: rtl/fl_test_utils_if.sv
// fl_test_utils_if: check bus from a stream source/sink into the monitor.
// Latency: n/a (wires only).
// Backpressure: none; every presented check is consumed while the monitor runs.
// Signals: chk_val, chk_dut, chk_ref, chk_mask, test_done.
interface fl_test_utils_if #(
  parameter int p_width = 32
) ();

  logic               chk_val;
  logic [p_width-1:0] chk_dut;
  logic [p_width-1:0] chk_ref;
  logic [p_width-1:0] chk_mask;
  logic               test_done;

  modport master (
    output chk_val,
    output chk_dut,
    output chk_ref,
    output chk_mask,
    output test_done
  );

  modport slave (
    input chk_val,
    input chk_dut,
    input chk_ref,
    input chk_mask,
    input test_done
  );

endinterface

// File: rtl/fl_sat_counter.sv
// fl_sat_counter: up-counter that holds at all-ones instead of wrapping.
// Latency: 1 cycle from en to cnt.
// Backpressure: none.
// Ports: clk, rst (async active-low clear), en (count this cycle), cnt.
module fl_sat_counter #(
  parameter int p_width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [p_width-1:0] cnt
);

  localparam logic [p_width-1:0] ONE = {{(p_width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/fl_test_utils.sv
// fl_test_utils: masked compare monitor with counters, first-mismatch capture and verdict.
// Latency: 1 cycle from a presented check to counters/fail/capture.
// Backpressure: none; checks are accepted every cycle in RUN and ignored in DONE.
// Ports: clk, rst (async active-low), chk (check bus slave), n_checks, n_fails, fail,
//        first_fail_idx/dut/ref, cycles, timeout, done, pass.
// Option: define FL_TEST_UTILS_TIMEOUT_EN to enable the p_timeout cycle watchdog.
module fl_test_utils
  import fl_test_utils_pkg::*;
#(
  parameter int p_width     = FL_DEFAULT_WIDTH,
  parameter int p_cnt_width = FL_DEFAULT_CNT_WIDTH,
  parameter int p_timeout   = FL_DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  fl_test_utils_if.slave            chk,
  output logic [p_cnt_width-1:0]    n_checks,
  output logic [p_cnt_width-1:0]    n_fails,
  output logic                      fail,
  output logic [p_cnt_width-1:0]    first_fail_idx,
  output logic [p_width-1:0]        first_fail_dut,
  output logic [p_width-1:0]        first_fail_ref,
  output logic [FL_CYCLE_WIDTH-1:0] cycles,
  output logic                      timeout,
  output logic                      done,
  output logic                      pass
);

  state_t state;
  state_t state_nxt;
  logic   running;
  logic   mismatch;
  logic   accept;
  logic   bad_check;
  logic   timeout_hit;

  assign running   = (state == ST_RUN);
  // Masked-off bits never contribute, so an all-zero mask always matches.
  assign mismatch  = |((chk.chk_dut ^ chk.chk_ref) & chk.chk_mask);
  assign accept    = chk.chk_val & running;
  assign bad_check = accept & mismatch;

`ifdef FL_TEST_UTILS_TIMEOUT_EN
  // Fire on the edge at which cycles becomes p_timeout, so cycles freezes at p_timeout.
  localparam logic [FL_CYCLE_WIDTH-1:0] TO_LAST = FL_CYCLE_WIDTH'(p_timeout - 1);
  assign timeout_hit = running && (cycles == TO_LAST);
`else
  localparam int unused_p_timeout = p_timeout;
  assign timeout_hit = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (chk.test_done || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_DONE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    done = (state == ST_DONE);
    pass = done & ~fail;
  end

  // ---------------- counters ----------------
  fl_sat_counter #(.p_width(p_cnt_width)) u_n_checks (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .cnt (n_checks)
  );

  fl_sat_counter #(.p_width(p_cnt_width)) u_n_fails (
    .clk (clk),
    .rst (rst),
    .en  (bad_check),
    .cnt (n_fails)
  );

  fl_sat_counter #(.p_width(FL_CYCLE_WIDTH)) u_cycles (
    .clk (clk),
    .rst (rst),
    .en  (running),
    .cnt (cycles)
  );

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (bad_check || timeout_hit) fail <= 1'b1;
      if (timeout_hit) timeout <= 1'b1;
    end
  end

  // ---------------- first-mismatch capture ----------------
  // fail is still clear on the first mismatching edge; a prior timeout would
  // have moved to DONE, so !fail uniquely marks "no mismatch captured yet".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_fail_idx <= '0;
      first_fail_dut <= '0;
      first_fail_ref <= '0;
    end else if (bad_check && !fail) begin
      first_fail_idx <= n_checks;
      first_fail_dut <= chk.chk_dut;
      first_fail_ref <= chk.chk_ref;
    end
  end

endmodule

// File: tb/tb_fl_test_utils.sv
// tb_fl_test_utils: directed bench for fl_test_utils.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_fl_test_utils;

  localparam int W  = 32;
  localparam int CW = 4;
`ifdef FL_TEST_UTILS_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 10000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] n_checks;
  logic [CW-1:0] n_fails;
  logic          fail;
  logic [CW-1:0] first_fail_idx;
  logic [W-1:0]  first_fail_dut;
  logic [W-1:0]  first_fail_ref;
  logic [31:0]   cycles;
  logic          timeout;
  logic          done;
  logic          pass;

  int passed = 0;
  int total  = 0;
  int tb_cycles;

  fl_test_utils_if #(.p_width(W)) chk_if ();

  fl_test_utils #(
    .p_width     (W),
    .p_cnt_width (CW),
    .p_timeout   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .chk            (chk_if),
    .n_checks       (n_checks),
    .n_fails        (n_fails),
    .fail           (fail),
    .first_fail_idx (first_fail_idx),
    .first_fail_dut (first_fail_dut),
    .first_fail_ref (first_fail_ref),
    .cycles         (cycles),
    .timeout        (timeout),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cycles <= 0;
    else      tb_cycles <= tb_cycles + 1;
  end

  task automatic idle();
    @(negedge clk);
    chk_if.chk_val   = 1'b0;
    chk_if.test_done = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] r,
                      input logic [W-1:0] m, input logic td);
    @(negedge clk);
    chk_if.chk_val   = 1'b1;
    chk_if.chk_dut   = d;
    chk_if.chk_ref   = r;
    chk_if.chk_mask  = m;
    chk_if.test_done = td;
  endtask

  task automatic mark_done();
    @(negedge clk);
    chk_if.chk_val   = 1'b0;
    chk_if.test_done = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_if.chk_val   = 1'b0;
    chk_if.test_done = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    chk_if.chk_val = 1'b0; chk_if.test_done = 1'b0;
    chk_if.chk_dut = '0; chk_if.chk_ref = '0; chk_if.chk_mask = '0;
    rst = 1'b0;
    #12;
    total++; if (n_checks !== 4'd0) $display("FAIL reset_n_checks got %0d want 0", n_checks); else passed++;
    total++; if (fail !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset_flags got fail=%b done=%b pass=%b timeout=%b want 0000", fail, done, pass, timeout); else passed++;
    total++; if (first_fail_dut !== 32'h0 || first_fail_ref !== 32'h0 || first_fail_idx !== 4'd0)
      $display("FAIL reset_capture got %0h/%0h/%0d want 0/0/0", first_fail_dut, first_fail_ref, first_fail_idx); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (cycles !== 32'd1) $display("FAIL reset_first_cycle got %0d want 1", cycles); else passed++;
  endtask

  task automatic test_match();
    do_reset();
    repeat (3) send(32'h0000_00A5, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);
    mark_done();
    idle();
    total++; if (n_checks !== 4'd3) $display("FAIL match_n_checks got %0d want 3", n_checks); else passed++;
    total++; if (n_fails !== 4'd0) $display("FAIL match_n_fails got %0d want 0", n_fails); else passed++;
    total++; if (fail !== 1'b0 || done !== 1'b1 || pass !== 1'b1)
      $display("FAIL match_verdict got fail=%b done=%b pass=%b want 0 1 1", fail, done, pass); else passed++;
  endtask

  task automatic test_mismatch();
    do_reset();
    send(32'h5,  32'h5,  32'hFFFF_FFFF, 1'b0);
    send(32'h12, 32'h13, 32'hFFFF_FFFF, 1'b0);
    send(32'hA,  32'hA,  32'hFFFF_FFFF, 1'b0);
    send(32'h3,  32'h3,  32'hFFFF_FFFF, 1'b0);
    send(32'h7,  32'h0,  32'hFFFF_FFFF, 1'b0);
    mark_done();
    idle();
    total++; if (n_checks !== 4'd5) $display("FAIL mism_n_checks got %0d want 5", n_checks); else passed++;
    total++; if (n_fails !== 4'd2) $display("FAIL mism_n_fails got %0d want 2", n_fails); else passed++;
    total++; if (first_fail_idx !== 4'd1) $display("FAIL mism_idx got %0d want 1", first_fail_idx); else passed++;
    total++; if (first_fail_dut !== 32'h12 || first_fail_ref !== 32'h13)
      $display("FAIL mism_capture got %0h/%0h want 12/13", first_fail_dut, first_fail_ref); else passed++;
    total++; if (fail !== 1'b1 || done !== 1'b1 || pass !== 1'b0)
      $display("FAIL mism_verdict got fail=%b done=%b pass=%b want 1 1 0", fail, done, pass); else passed++;
  endtask

  task automatic test_mask();
    do_reset();
    send(32'hFF, 32'h0F, 32'h0F, 1'b0);
    idle();
    total++; if (n_fails !== 4'd0 || fail !== 1'b0)
      $display("FAIL mask_low_nibble got n_fails=%0d fail=%b want 0 0", n_fails, fail); else passed++;
    send(32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    idle();
    total++; if (n_fails !== 4'd0) $display("FAIL mask_zero got n_fails=%0d want 0", n_fails); else passed++;
    send(32'hFF, 32'h0F, 32'hF0, 1'b0);
    idle();
    total++; if (n_fails !== 4'd1 || n_checks !== 4'd3)
      $display("FAIL mask_high_nibble got n_fails=%0d n_checks=%0d want 1 3", n_fails, n_checks); else passed++;
    total++; if (first_fail_idx !== 4'd2 || first_fail_dut !== 32'hFF || first_fail_ref !== 32'h0F)
      $display("FAIL mask_capture got %0d/%0h/%0h want 2/ff/f", first_fail_idx, first_fail_dut, first_fail_ref); else passed++;
  endtask

  task automatic test_same_cycle();
    int exp_cyc;
    do_reset();
    send(32'h1,  32'h1,  32'hFFFF_FFFF, 1'b0);
    send(32'h12, 32'h34, 32'hFFFF_FFFF, 1'b1);
    idle();
    total++; if (n_checks !== 4'd2 || n_fails !== 4'd1)
      $display("FAIL same_counts got %0d/%0d want 2/1", n_checks, n_fails); else passed++;
    total++; if (fail !== 1'b1 || done !== 1'b1 || first_fail_idx !== 4'd1)
      $display("FAIL same_flags got fail=%b done=%b idx=%0d want 1 1 1", fail, done, first_fail_idx); else passed++;
    exp_cyc = tb_cycles;
    send(32'h55, 32'h66, 32'hFFFF_FFFF, 1'b0);
    repeat (4) idle();
    total++; if (n_checks !== 4'd2 || n_fails !== 4'd1 || first_fail_dut !== 32'h12)
      $display("FAIL same_frozen got %0d/%0d/%0h want 2/1/12", n_checks, n_fails, first_fail_dut); else passed++;
    total++; if (cycles !== 32'(exp_cyc)) $display("FAIL same_cycles_frozen got %0d want %0d", cycles, exp_cyc); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (18) send(32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    idle();
    total++; if (n_checks !== 4'hF || n_fails !== 4'hF)
      $display("FAIL sat_counts got %0d/%0d want 15/15", n_checks, n_fails); else passed++;
    total++; if (first_fail_idx !== 4'd0 || first_fail_ref !== 32'h1)
      $display("FAIL sat_capture got %0d/%0h want 0/1", first_fail_idx, first_fail_ref); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (30) idle();
`ifdef FL_TEST_UTILS_TIMEOUT_EN
    total++; if (timeout !== 1'b1 || fail !== 1'b1 || done !== 1'b1 || pass !== 1'b0)
      $display("FAIL to_flags got timeout=%b fail=%b done=%b pass=%b want 1 1 1 0", timeout, fail, done, pass); else passed++;
    total++; if (cycles !== 32'd20) $display("FAIL to_cycles got %0d want 20", cycles); else passed++;
`else
    total++; if (timeout !== 1'b0 || fail !== 1'b0 || done !== 1'b0)
      $display("FAIL to_disabled got timeout=%b fail=%b done=%b want 0 0 0", timeout, fail, done); else passed++;
    total++; if (cycles !== 32'(tb_cycles)) $display("FAIL to_cycles got %0d want %0d", cycles, tb_cycles); else passed++;
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(32'h3, 32'h4, 32'hFFFF_FFFF, 1'b0);
    send(32'h5, 32'h5, 32'hFFFF_FFFF, 1'b0);
    idle();
    total++; if (n_checks !== 4'd2 || first_fail_dut !== 32'h3)
      $display("FAIL midrst_pre got %0d/%0h want 2/3", n_checks, first_fail_dut); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (n_checks !== 4'd0 || n_fails !== 4'd0 || cycles !== 32'd0)
      $display("FAIL midrst_counts got %0d/%0d/%0d want 0/0/0", n_checks, n_fails, cycles); else passed++;
    total++; if (fail !== 1'b0 || timeout !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
      $display("FAIL midrst_flags got %b%b%b%b want 0000", fail, timeout, done, pass); else passed++;
    total++; if (first_fail_idx !== 4'd0 || first_fail_dut !== 32'h0 || first_fail_ref !== 32'h0)
      $display("FAIL midrst_capture got %0d/%0h/%0h want 0/0/0", first_fail_idx, first_fail_dut, first_fail_ref); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_mask();
    test_same_cycle();
    test_saturate();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
